// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    StRun,
    StMacWait
  } hazard_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard compare between IF/D sources and the ID/EX load target.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  output logic                 load_use
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush control for load-use, taken branches and multi-cycle MAC instructions.
// Optional MAC timeout abort is compiled in with HAZARD_MAC_TIMEOUT_EN.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MAC_TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W              = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_branch_taken,
  input  logic                 id_is_mac,
  input  logic                 mac_done,
  output logic                 IFD_register_hold,
  output logic                 pc_hold,
  output logic                 ifd_flush,
  output logic                 idex_bubble,
  output logic                 mac_start,
  output logic                 mac_error,
  output logic [CNT_W-1:0]     stall_count
);

  hazard_state_e state_q, state_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic load_use;
  logic hold_raw, pc_hold_raw, flush_raw, bubble_raw, start_raw, error_raw;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

`ifdef HAZARD_MAC_TIMEOUT_EN
  localparam int unsigned TmoW = (MAC_TIMEOUT_CYCLES > 1) ? $clog2(MAC_TIMEOUT_CYCLES) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(MAC_TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_hit;

  assign tmo_hit = (tmo_q == TmoLast);

  // Held at zero outside MAC_WAIT so every MAC_WAIT entry starts from a clean count.
  always_comb begin
    tmo_d = '0;
    if (state_q == StMacWait && !mac_done && !tmo_hit) begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic tmo_hit;
  logic unused_tmo_cfg;

  assign tmo_hit        = 1'b0;
  assign unused_tmo_cfg = ^MAC_TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    hold_raw    = 1'b0;
    pc_hold_raw = 1'b0;
    flush_raw   = 1'b0;
    bubble_raw  = 1'b0;
    start_raw   = 1'b0;
    error_raw   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (ex_branch_taken) begin
          flush_raw  = 1'b1;
          bubble_raw = 1'b1;
        end else if (load_use) begin
          hold_raw    = 1'b1;
          pc_hold_raw = 1'b1;
          bubble_raw  = 1'b1;
        end else if (id_is_mac) begin
          start_raw   = 1'b1;
          hold_raw    = 1'b1;
          pc_hold_raw = 1'b1;
          bubble_raw  = 1'b1;
          state_d     = StMacWait;
        end
      end
      StMacWait: begin
        // Taken branches are ignored here: ID/EX only ever holds a bubble while waiting.
        if (mac_done) begin
          flush_raw = 1'b1;
          state_d   = StRun;
        end else if (tmo_hit) begin
          error_raw  = 1'b1;
          flush_raw  = 1'b1;
          bubble_raw = 1'b1;
          state_d    = StRun;
        end else begin
          hold_raw    = 1'b1;
          pc_hold_raw = 1'b1;
          bubble_raw  = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Outputs are forced low for the whole time reset is held, independent of inputs.
  assign IFD_register_hold = reset & hold_raw;
  assign pc_hold           = reset & pc_hold_raw;
  assign ifd_flush         = reset & flush_raw;
  assign idex_bubble       = reset & bubble_raw;
  assign mac_start         = reset & start_raw;
  assign mac_error         = reset & error_raw;

  always_comb begin
    stall_count_d = stall_count_q;
    if (pc_hold) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StRun;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
